throw_control: RTL

//  Turn/throw initiator for the cat-vs-dog game; drives the particle simulator's throw inputs.
//  - Charges throw speed while the active player holds the mouse button.
//  - Issues a one-cycle throw_flag on release, then waits for the simulator's end_throw.
//  - Alternates turns and flags game over when a player's HP is exhausted.
//  - Sits between mouse/player-select logic and the particle simulator; 60 MHz domain.

---
 rtl/throw_control.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/throw_control.sv
// Turn/throw initiator for the cat-vs-dog game: charges speed, fires the throw, alternates turns.
// Optional build macro SPEED_PINGPONG_EN makes the charge speed bounce between SPEED_MIN and SPEED_MAX.
module throw_control #(
  parameter int unsigned CHARGE_TICKS   = 3_000_000,
  parameter int unsigned SPEED_MIN      = 1,
  parameter int unsigned SPEED_MAX      = 31,
  parameter int unsigned FLIGHT_TIMEOUT = 180_000_000
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       btn_left,
  input  logic [1:0] current_player,
  input  logic       end_throw,
  input  logic [6:0] hp_player1,
  input  logic [6:0] hp_player2,
  output logic       throw_flag,
  output logic       turn,
  output logic [4:0] speed,
  output logic       charging,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [1:0] PLAYER_1 = 2'd1;
  localparam logic [1:0] PLAYER_2 = 2'd2;

  localparam int TICK_W = (CHARGE_TICKS > 1) ? $clog2(CHARGE_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(CHARGE_TICKS - 1);
  localparam logic [27:0]       FLIGHT_LAST = 28'(FLIGHT_TIMEOUT - 1);
  localparam logic [4:0]        S_MIN       = 5'(SPEED_MIN);
  localparam logic [4:0]        S_MAX       = 5'(SPEED_MAX);

  typedef enum logic [2:0] {IDLE, CHARGE, FLIGHT, CHECK, OVER} state_e;

  state_e            state_q, state_d;
  logic              btn_q, btn_prev_q;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [27:0]       flight_q, flight_d;
  logic [4:0]        speed_q, speed_d;
  logic              turn_q, turn_d;
  logic              throw_q, throw_d;
  logic [1:0]        winner_q, winner_d;
  logic [6:0]        hp1_q, hp1_d, hp2_q, hp2_d;
  logic              hp_valid_q, hp_valid_d;
`ifdef SPEED_PINGPONG_EN
  logic              dir_q, dir_d;
`endif

  logic press, release_w, owner, hp1_dead, hp2_dead;

  assign press     =  btn_q & ~btn_prev_q;
  assign release_w = ~btn_q &  btn_prev_q;
  assign owner     = (!turn_q && current_player == PLAYER_1) ||
                     ( turn_q && current_player == PLAYER_2);
  // hp above 100 can only come from a 7-bit underflow in the simulator
  assign hp1_dead  = (hp1_q == 7'd0) || (hp1_q > 7'd100);
  assign hp2_dead  = (hp2_q == 7'd0) || (hp2_q > 7'd100);

  always_ff @(posedge clk60MHz) begin
    btn_prev_q <= btn_q;
    btn_q      <= btn_left;
    if (rst) begin
      btn_q      <= btn_left;
      btn_prev_q <= btn_left;
      state_q    <= IDLE;
      tick_q     <= '0;
      flight_q   <= '0;
      speed_q    <= S_MIN;
      turn_q     <= 1'b0;
      throw_q    <= 1'b0;
      winner_q   <= 2'd0;
      hp1_q      <= '0;
      hp2_q      <= '0;
      hp_valid_q <= 1'b0;
`ifdef SPEED_PINGPONG_EN
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      flight_q   <= flight_d;
      speed_q    <= speed_d;
      turn_q     <= turn_d;
      throw_q    <= throw_d;
      winner_q   <= winner_d;
      hp1_q      <= hp1_d;
      hp2_q      <= hp2_d;
      hp_valid_q <= hp_valid_d;
`ifdef SPEED_PINGPONG_EN
      dir_q      <= dir_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    flight_d   = flight_q;
    speed_d    = speed_q;
    turn_d     = turn_q;
    throw_d    = 1'b0;
    winner_d   = winner_q;
    hp1_d      = hp1_q;
    hp2_d      = hp2_q;
    hp_valid_d = hp_valid_q;
`ifdef SPEED_PINGPONG_EN
    dir_d      = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (press && owner) begin
          state_d = CHARGE;
          speed_d = S_MIN;
          tick_d  = '0;
`ifdef SPEED_PINGPONG_EN
          dir_d   = 1'b0;
`endif
        end
      end
      CHARGE: begin
        // a release wins over a speed step landing on the same cycle
        if (release_w) begin
          state_d    = FLIGHT;
          throw_d    = 1'b1;
          flight_d   = '0;
          hp_valid_d = 1'b0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
`ifdef SPEED_PINGPONG_EN
          if (!dir_q) begin
            if (speed_q >= S_MAX) begin
              dir_d   = 1'b1;
              speed_d = S_MAX - 5'd1;
            end else begin
              speed_d = speed_q + 5'd1;
            end
          end else begin
            if (speed_q <= S_MIN) begin
              dir_d   = 1'b0;
              speed_d = S_MIN + 5'd1;
            end else begin
              speed_d = speed_q - 5'd1;
            end
          end
`else
          speed_d = (speed_q >= S_MAX) ? S_MAX : speed_q + 5'd1;
`endif
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      FLIGHT: begin
        if (end_throw) begin
          state_d    = CHECK;
          hp1_d      = hp_player1;
          hp2_d      = hp_player2;
          hp_valid_d = 1'b1;
        end else if (flight_q == FLIGHT_LAST) begin
          state_d = CHECK;
        end else begin
          flight_d = flight_q + 28'd1;
        end
      end
      CHECK: begin
        // a timed-out flight carries no fresh hp, so it only hands over the turn
        if (hp_valid_q && hp2_dead) begin
          state_d  = OVER;
          winner_d = PLAYER_1;
        end else if (hp_valid_q && hp1_dead) begin
          state_d  = OVER;
          winner_d = PLAYER_2;
        end else begin
          state_d = IDLE;
          turn_d  = ~turn_q;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    throw_flag = throw_q;
    turn       = turn_q;
    speed      = speed_q;
    charging   = (state_q == CHARGE);
    game_over  = (state_q == OVER);
    winner     = (state_q == OVER) ? winner_q : 2'd0;
  end

endmodule
